// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC datapath: accepts one job, drives
// the load and micro-rotation cycles, then returns the captured result.
module cordic_seq_ctrl #(
   parameter int FIXED_POINT = 14,
   parameter int ANGLE_W     = 17,
   parameter int ITERATIONS  = 14,
   parameter int SHIFT_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ANGLE_W-1:0]     req_theta,
   input  logic [FIXED_POINT-1:0] req_x,
   input  logic [FIXED_POINT-1:0] req_y,
   output logic [ANGLE_W-1:0]     cordic_theta,
   output logic [FIXED_POINT-1:0] cordic_x,
   output logic [FIXED_POINT-1:0] cordic_y,
   output logic                   cordic_enable,
   output logic                   cordic_load,
   output logic [SHIFT_W-1:0]     cordic_shift,
   input  logic [FIXED_POINT-1:0] cordic_x_out,
   input  logic [FIXED_POINT-1:0] cordic_y_out,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [FIXED_POINT-1:0] res_x,
   output logic [FIXED_POINT-1:0] res_y,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_CAPT,
      S_DONE
   } state_t;

   localparam logic [SHIFT_W-1:0] K_LAST = SHIFT_W'(ITERATIONS - 1);

   state_t             state;
   state_t             state_nxt;
   logic [SHIFT_W-1:0] k;
   logic [SHIFT_W-1:0] k_nxt;
   logic               accept;

   assign req_ready = (state == S_IDLE) && !flush;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (accept) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_ITER;
            S_ITER: if (k == K_LAST) state_nxt = S_CAPT;
            S_CAPT: state_nxt = S_DONE;
            S_DONE: if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cordic_enable = 1'b0;
      cordic_load   = 1'b0;
      res_valid     = 1'b0;
      busy          = (state != S_IDLE);
      unique case (state)
         S_LOAD: cordic_enable = 1'b1;
         S_ITER: begin
            cordic_enable = 1'b1;
            cordic_load   = 1'b1;
         end
         S_DONE: res_valid = 1'b1;
         default: ;
      endcase
   end

   // k is zero outside ITER, so it doubles as the registered shift output
   always_comb begin
      k_nxt = '0;
      if (!flush && state == S_ITER && k != K_LAST) begin
         k_nxt = k + SHIFT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k <= '0;
      end else begin
         k <= k_nxt;
      end
   end

   assign cordic_shift = k;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cordic_theta <= '0;
         cordic_x     <= '0;
         cordic_y     <= '0;
      end else if (accept) begin
         cordic_theta <= req_theta;
         cordic_x     <= req_x;
         cordic_y     <= req_y;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_x <= '0;
         res_y <= '0;
      end else if (state == S_CAPT && !flush) begin
         res_x <= cordic_x_out;
         res_y <= cordic_y_out;
      end
   end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: job-phase reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cordic_seq_ctrl;

   localparam int N = 14;

   logic        clk_tb = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [16:0] req_theta = '0;
   logic [13:0] req_x = '0;
   logic [13:0] req_y = '0;
   logic [16:0] cordic_theta;
   logic [13:0] cordic_x;
   logic [13:0] cordic_y;
   logic        cordic_enable;
   logic        cordic_load;
   logic [3:0]  cordic_shift;
   logic [13:0] cordic_x_out = '0;
   logic [13:0] cordic_y_out = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [13:0] res_x;
   logic [13:0] res_y;
   logic        busy;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   cordic_seq_ctrl dut (
      .clk          (clk_tb),
      .rst          (rst),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_theta    (req_theta),
      .req_x        (req_x),
      .req_y        (req_y),
      .cordic_theta (cordic_theta),
      .cordic_x     (cordic_x),
      .cordic_y     (cordic_y),
      .cordic_enable(cordic_enable),
      .cordic_load  (cordic_load),
      .cordic_shift (cordic_shift),
      .cordic_x_out (cordic_x_out),
      .cordic_y_out (cordic_y_out),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_x        (res_x),
      .res_y        (res_y),
      .busy         (busy)
   );

   always #5 clk_tb = ~clk_tb;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   // Model: t = cycles since acceptance (-1 idle, 0 load, 1..N rotate,
   // N+1 capture, N+2 result waiting)
   int          t = -1;
   logic [16:0] m_th = '0;
   logic [13:0] m_x = '0;
   logic [13:0] m_y = '0;
   logic [13:0] m_rx = '0;
   logic [13:0] m_ry = '0;

   always @(posedge clk_tb or negedge rst) begin
      if (!rst) begin
         t = -1;
         m_th = '0; m_x = '0; m_y = '0;
         m_rx = '0; m_ry = '0;
      end else if (flush) begin
         t = -1;
      end else if (t == -1) begin
         if (req_valid) begin
            t = 0;
            m_th = req_theta; m_x = req_x; m_y = req_y;
         end
      end else if (t == N + 1) begin
         m_rx = cordic_x_out;
         m_ry = cordic_y_out;
         t = N + 2;
      end else if (t == N + 2) begin
         if (res_ready) t = -1;
      end else begin
         t = t + 1;
      end
   end

   always @(negedge clk_tb) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'((t == -1) && !flush));
         chk("busy", 32'(busy), 32'(t != -1));
         chk("enable", 32'(cordic_enable), 32'(t >= 0 && t <= N));
         chk("load", 32'(cordic_load), 32'(t >= 1 && t <= N));
         chk("shift", 32'(cordic_shift),
             (t >= 1 && t <= N) ? t - 1 : 0);
         chk("res_valid", 32'(res_valid), 32'(t == N + 2));
         chk("res_x", 32'(res_x), 32'(m_rx));
         chk("res_y", 32'(res_y), 32'(m_ry));
         chk("op_theta", 32'(cordic_theta), 32'(m_th));
         chk("op_x", 32'(cordic_x), 32'(m_x));
         chk("op_y", 32'(cordic_y), 32'(m_y));
      end
   end

   // datapath stand-in: fresh random results every cycle
   always @(posedge clk_tb) begin
      #1;
      cordic_x_out = 14'($urandom);
      cordic_y_out = 14'($urandom);
   end

   task automatic edge_();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic wait_rv();
      int n = 0;
      while (!res_valid && n < 60) begin
         edge_();
         n++;
      end
      chk("rv_timeout", 32'(res_valid), 32'(1));
   endtask

   task automatic job(input logic [16:0] th, input logic [13:0] x,
                      input logic [13:0] y);
      req_theta = th; req_x = x; req_y = y;
      req_valid = 1'b1;
      edge_();
      req_valid = 1'b0;
   endtask

   initial begin
      int first_rv;
      int nload;
      int exp_k;
      bit seq_ok;
      logic [13:0] hx;
      logic [13:0] hy;

      repeat (3) edge_();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rv", 32'(res_valid), 32'(0));
      rst = 1'b1;
      #1;
      chk("rst_ready", 32'(req_ready), 32'(1));
      chk_en = 1'b1;
      edge_();

      // single job: literal timing and shift sequence
      res_ready = 1'b1;
      job(17'h0860B, 14'h0800, 14'h0000);
      chk("s1_busy_e0", 32'(busy), 32'(1));
      first_rv = -1; nload = 0; exp_k = 0; seq_ok = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         edge_();
         if (res_valid && first_rv < 0) first_rv = i;
         if (cordic_load) begin
            if (32'(cordic_shift) != exp_k) seq_ok = 1'b0;
            exp_k++;
            nload++;
         end
         if (i == 16) chk("s1_busy_e16", 32'(busy), 32'(1));
         if (i == 17) chk("s1_busy_e17", 32'(busy), 32'(0));
      end
      chk("s1_rv_edge", first_rv, 16);
      chk("s1_nload", nload, 14);
      chk("s1_shift_seq", 32'(seq_ok), 32'(1));

      // backpressure
      res_ready = 1'b0;
      job(17'h1F0F0, 14'h1234, 14'h0ABC);
      wait_rv();
      hx = res_x; hy = res_y;
      repeat (10) edge_();
      chk("bp_rv", 32'(res_valid), 32'(1));
      chk("bp_hold_x", 32'(res_x), 32'(hx));
      chk("bp_hold_y", 32'(res_y), 32'(hy));
      chk("bp_ready", 32'(req_ready), 32'(0));
      res_ready = 1'b1;
      edge_();
      chk("bp_idle", 32'(req_ready), 32'(1));
      chk("bp_busy", 32'(busy), 32'(0));

      // back-to-back with req_valid held
      req_theta = 17'h00123; req_x = 14'h0111; req_y = 14'h0222;
      req_valid = 1'b1;
      edge_();
      wait_rv();
      req_theta = 17'h0ABCD; req_x = 14'h3333; req_y = 14'h2222;
      edge_();
      chk("b2b_idle_busy", 32'(busy), 32'(0));
      chk("b2b_idle_ready", 32'(req_ready), 32'(1));
      edge_();
      req_valid = 1'b0;
      chk("b2b_load_en", 32'(cordic_enable), 32'(1));
      chk("b2b_load_ld", 32'(cordic_load), 32'(0));
      edge_();
      chk("b2b_shift0", 32'(cordic_shift), 32'(0));
      wait_rv();
      edge_();

      // flush at k=5
      job(17'h00F00, 14'h0700, 14'h0070);
      repeat (6) edge_();
      chk("fl_k5", 32'(cordic_shift), 32'(5));
      flush = 1'b1;
      edge_();
      flush = 1'b0;
      chk("fl_en", 32'(cordic_enable), 32'(0));
      chk("fl_shift", 32'(cordic_shift), 32'(0));
      chk("fl_busy", 32'(busy), 32'(0));
      repeat (20) edge_();
      job(17'h0860B, 14'h0800, 14'h0000);
      wait_rv();
      edge_();

      // async reset pulse while result is waiting
      res_ready = 1'b0;
      job(17'h05555, 14'h2AAA, 14'h1555);
      wait_rv();
      #2;
      rst = 1'b0;
      #1;
      chk("ar_rv", 32'(res_valid), 32'(0));
      chk("ar_x", 32'(res_x), 32'(0));
      chk("ar_y", 32'(res_y), 32'(0));
      chk("ar_ready", 32'(req_ready), 32'(1));
      rst = 1'b1;
      res_ready = 1'b1;
      edge_();
      job(17'h0860B, 14'h0800, 14'h0000);
      wait_rv();
      edge_();

      // flush with request in IDLE
      flush = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("fi_ready", 32'(req_ready), 32'(0));
      edge_();
      chk("fi_busy", 32'(busy), 32'(0));
      flush = 1'b0;
      edge_();
      req_valid = 1'b0;
      chk("fi_accept", 32'(busy), 32'(1));
      wait_rv();
      edge_();

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         res_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         req_theta = 17'($urandom);
         req_x     = 14'($urandom);
         req_y     = 14'($urandom);
         edge_();
      end
      flush = 1'b0;
      req_valid = 1'b0;
      res_ready = 1'b1;
      repeat (25) edge_();
      chk("end_idle", 32'(busy), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cordic_seq_ctrl.md
Name: cordic_seq_ctrl

Overview:
- Sequencer that owns the Cordic iterative datapath and replaces hand-driven load, enable and shift stimulus.
- Accepts one rotation job through a valid/ready request port and presents operands to the datapath.
- Drives one load cycle, then ITERATIONS micro-rotation cycles with an incrementing shift value.
- Captures the datapath outputs and returns them through a valid/ready result port. Exactly one job is in flight at a time.

Parameters:
- FIXED_POINT, 14, width of the x/y fixed-point operands and results.
- ANGLE_W, 17, width of the theta_rad angle operand.
- ITERATIONS, 14, number of micro-rotations per job; range 1..16.
- SHIFT_W, 4, width of the shift value; must satisfy 2^SHIFT_W >= ITERATIONS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; wins over every other event.
- req_valid  in  1  job request valid.
- req_ready  out  1  controller can accept a job.
- req_theta  in  ANGLE_W  rotation angle in radians, fixed point.
- req_x  in  FIXED_POINT  initial x.
- req_y  in  FIXED_POINT  initial y.
- cordic_theta  out  ANGLE_W  angle operand to the datapath.
- cordic_x  out  FIXED_POINT  x operand to the datapath.
- cordic_y  out  FIXED_POINT  y operand to the datapath.
- cordic_enable  out  1  datapath enable.
- cordic_load  out  1  0 = load operands; 1 = perform a micro-rotation (valid only while enable=1).
- cordic_shift  out  SHIFT_W  iteration index / shift amount.
- cordic_x_out  in  FIXED_POINT  datapath x result.
- cordic_y_out  in  FIXED_POINT  datapath y result.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_x  out  FIXED_POINT  captured x result.
- res_y  out  FIXED_POINT  captured y result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - Operand, result and iteration registers clear to 0.
  - cordic_enable, cordic_load, cordic_shift, res_valid and busy are 0.
  - req_ready is 1 after reset provided flush=0.
- Handshakes:
  - req_ready = (state==IDLE) && !flush, combinational.
  - A job is accepted on an edge where req_valid && req_ready.
  - On acceptance, req_theta, req_x and req_y are registered into cordic_theta, cordic_x and cordic_y. These outputs hold until the next acceptance.
- States:
  - IDLE: enable=0, load=0, shift=0. On acceptance, go to LOAD.
  - LOAD (1 cycle): enable=1, load=0, shift=0. Go to ITER with k=0.
  - ITER: enable=1, load=1, shift=k.
    - k increments by 1 each cycle.
    - In the cycle where k==ITERATIONS-1, go to CAPT.
  - CAPT (1 cycle): enable=0, load=0, shift=0. At the end of this cycle, register cordic_x_out and cordic_y_out into res_x and res_y. Go to DONE.
  - DONE: res_valid=1.
    - res_x and res_y are held stable until the result is taken.
    - On res_valid && res_ready, return to IDLE and drop res_valid on that edge.
- Latency: with acceptance at edge E0, res_valid rises after edge E(ITERATIONS+2), which is E16 at the defaults.
- No overlap: a new job can first be accepted on the edge after the result handshake completes.
- cordic_shift is registered and glitch-free.
  - Exact sequence over a job: 0 in LOAD, then 0,1,...,ITERATIONS-1 in ITER.
  - It never wraps within a job.
- flush=1 sampled on an edge:
  - Next state is IDLE and the iteration counter clears.
  - Any pending result is discarded: res_valid falls, and res_x/res_y keep their old value.
  - No request is accepted on that edge.
- res_ready while res_valid=0 is ignored. req_valid outside IDLE is ignored; req_ready is 0 there.
- Asynchronous reset mid-job aborts the job exactly like flush, additionally clearing all registers.

Test Plan:
- Single job: req_x=14'h0800, req_y=0, req_theta=17'h0860B, res_ready=1.
  - Accepted at E0.
  - cordic_load=0 for 1 cycle, then 1 for 14 cycles with cordic_shift 0..13.
  - res_valid after E16; res_x/res_y equal cordic_x_out/cordic_y_out sampled at E16.
  - busy is high E0..E17.
- Backpressure: same job with res_ready=0 for 10 cycles.
  - res_valid stays 1, res_x/res_y are stable, req_ready stays 0.
  - After res_ready=1, state returns to IDLE one edge later and req_ready=1.
- Back-to-back: req_valid held high with res_ready=1.
  - The second job is accepted exactly one edge after the first result handshake.
  - The second shift sequence restarts at 0.
- Flush during ITER at k=5:
  - The next cycle shows enable=0, shift=0, busy=0; res_valid never asserts.
  - A following job completes with the full 0..13 sequence.
- Async reset pulse (rst=0 for 1 ns, between edges) during DONE:
  - res_valid, res_x and res_y are 0 immediately.
  - req_ready=1.
  - The next job behaves as in scenario 1.
- Flush and req_valid together in IDLE: no acceptance and busy stays 0. The request is accepted on the next edge with flush=0.
